// File: rtl/rx_frame_ctrl.sv
`timescale 1ns/1ps
// rx_frame_ctrl: frame parser behind the UART byte receiver.
// It hunts for SYNC_BYTE, then reads a LEN byte, LEN payload bytes and an XOR
// checksum byte. A good frame is held in an internal buffer until the consumer
// has popped every byte. Bad length, bad checksum, inter-byte timeout and bytes
// arriving while a frame is held are discarded, each with a one-cycle pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   byte_in         received byte, sampled when byte_valid=1
//   byte_valid      one-cycle strobe from the UART receiver
//   rd_en           consumer pops one payload byte (HOLD only)
//   rd_data         payload byte at the read pointer (combinational)
//   frame_ready     a checksum-good frame is held
//   frame_len       payload length of the held frame (0 when not ready)
//   busy            parsing a frame (LEN, PAYLOAD or CKSUM)
//   err_cksum/err_len/err_timeout/err_overrun  one-cycle discard pulses
module rx_frame_ctrl #(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          frame_ready,
  output logic [LW-1:0] frame_len,
  output logic          busy,
  output logic          err_cksum,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_overrun
);

  // Buffer index width; pointers carry one extra bit so they can hold MAX_LEN.
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StCksum,
    StHold
  } state_e;

  state_e          st_q;
  logic [7:0]      buf_q [MAX_LEN];
  logic [LW-1:0]   wr_ptr_q;
  logic [LW-1:0]   rd_ptr_q;
  logic [LW-1:0]   len_q;
  logic [7:0]      acc_q;
  logic [TW-1:0]   to_cnt_q;
  logic            err_cksum_q;
  logic            err_len_q;
  logic            err_timeout_q;
  logic            err_overrun_q;

  logic [LW-1:0]   len_last;
  logic            busy_st;
  logic            len_bad;
  logic            timeout_hit;
  logic            buf_we;

  assign len_last    = len_q - LW'(1);
  assign busy_st     = (st_q == StLen) || (st_q == StPayload) || (st_q == StCksum);
  assign len_bad     = (byte_in == 8'd0) || (byte_in > 8'(MAX_LEN));
  assign timeout_hit = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign buf_we      = (st_q == StPayload) && byte_valid;

  // Payload storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[wr_ptr_q[IW-1:0]] <= byte_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q          <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      len_q         <= '0;
      acc_q         <= '0;
      to_cnt_q      <= '0;
      err_cksum_q   <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_cksum_q   <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;

      // Inter-byte watchdog. A byte in the expiry cycle wins, so the timeout
      // branch never competes with a byte-driven state change below.
      if (!busy_st || byte_valid) begin
        to_cnt_q <= '0;
      end else if (timeout_hit) begin
        to_cnt_q      <= '0;
        err_timeout_q <= 1'b1;
        st_q          <= StIdle;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      unique case (st_q)
        StIdle: begin
          if (byte_valid && (byte_in == SYNC_BYTE)) begin
            st_q <= StLen;
          end
        end
        StLen: begin
          if (byte_valid) begin
            if (len_bad) begin
              // The rejected length byte is consumed, never re-read as sync.
              err_len_q <= 1'b1;
              st_q      <= StIdle;
            end else begin
              len_q    <= byte_in[LW-1:0];
              acc_q    <= byte_in;
              wr_ptr_q <= '0;
              st_q     <= StPayload;
            end
          end
        end
        StPayload: begin
          if (byte_valid) begin
            acc_q    <= acc_q ^ byte_in;
            wr_ptr_q <= wr_ptr_q + LW'(1);
            if (wr_ptr_q == len_last) begin
              st_q <= StCksum;
            end
          end
        end
        StCksum: begin
          if (byte_valid) begin
            if (byte_in == acc_q) begin
              rd_ptr_q <= '0;
              st_q     <= StHold;
            end else begin
              err_cksum_q <= 1'b1;
              st_q        <= StIdle;
            end
          end
        end
        StHold: begin
          // No back-pressure to the UART: anything arriving now is lost.
          if (byte_valid) begin
            err_overrun_q <= 1'b1;
          end
          if (rd_en) begin
            if (rd_ptr_q == len_last) begin
              st_q <= StIdle;
            end else begin
              rd_ptr_q <= rd_ptr_q + LW'(1);
            end
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign rd_data     = buf_q[rd_ptr_q[IW-1:0]];
  assign frame_ready = (st_q == StHold);
  assign frame_len   = (st_q == StHold) ? len_q : '0;
  assign busy        = busy_st;
  assign err_cksum   = err_cksum_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
`timescale 1ns/1ps
module tb_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       frame_ready;
  logic [4:0] frame_len;
  logic       busy;
  logic       err_cksum;
  logic       err_len;
  logic       err_timeout;
  logic       err_overrun;
  logic [3:0] errs;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  rx_frame_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .busy        (busy),
    .err_cksum   (err_cksum),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  // {cksum, len, timeout, overrun}
  assign errs = {err_cksum, err_len, err_timeout, err_overrun};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    #1;
    check_eq(tag, {24'd0, rd_data}, {24'd0, exp});
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  // Checks a pulse now and that it is gone one cycle later.
  task automatic pulse(input string tag, input logic [3:0] exp);
    check_eq(tag, {28'd0, errs}, {28'd0, exp});
    tick(1);
    check_eq({tag, "_gone"}, {28'd0, errs}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    rd_en      = 1'b0;
    tick(2);
    check_eq("rst_ready", {31'd0, frame_ready}, 32'd0);
    check_eq("rst_len", {27'd0, frame_len}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_errs", {28'd0, errs}, 32'd0);
    rst = 1'b0;
    tick(1);

    // Good frame A5 03 11 22 33 03.
    send(8'hA5);
    check_eq("good_busy", {31'd0, busy}, 32'd1);
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    check_eq("good_not_ready", {31'd0, frame_ready}, 32'd0);
    send(8'h03);
    check_eq("good_ready", {31'd0, frame_ready}, 32'd1);
    check_eq("good_len", {27'd0, frame_len}, 32'd3);
    check_eq("good_busy_off", {31'd0, busy}, 32'd0);
    pop("good_pop0", 8'h11);
    pop("good_pop1", 8'h22);
    check_eq("good_ready_mid", {31'd0, frame_ready}, 32'd1);
    pop("good_pop2", 8'h33);
    check_eq("good_ready_fall", {31'd0, frame_ready}, 32'd0);

    // Bad checksum: 02^10^20 = 32, sent 31.
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    check_eq("cks_ready", {31'd0, frame_ready}, 32'd0);
    pulse("cks_err", 4'b1000);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    check_eq("cks_next_ready", {31'd0, frame_ready}, 32'd1);
    check_eq("cks_next_len", {27'd0, frame_len}, 32'd2);
    pop("cks_next_pop0", 8'h10);
    pop("cks_next_pop1", 8'h20);
    check_eq("cks_next_done", {31'd0, frame_ready}, 32'd0);

    // Length errors; A5 as a length must not restart the hunt.
    send(8'hA5); send(8'h00);
    check_eq("len0_busy", {31'd0, busy}, 32'd0);
    pulse("len0_err", 4'b0100);
    send(8'hA5); send(8'h11);
    check_eq("len17_busy", {31'd0, busy}, 32'd0);
    pulse("len17_err", 4'b0100);
    send(8'hA5); send(8'hA5);
    pulse("lenA5_err", 4'b0100);
    send(8'h01);
    check_eq("lenA5_no_resync", {31'd0, busy}, 32'd0);

    // Maximum length 16: payload 01..10, checksum 10 ^ (01^..^10) = 00.
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= 16; i++) send(8'(i));
    send(8'h00);
    check_eq("max_ready", {31'd0, frame_ready}, 32'd1);
    check_eq("max_len", {27'd0, frame_len}, 32'd16);
    for (int i = 1; i <= 16; i++) pop($sformatf("max_pop%0d", i), 8'(i));
    check_eq("max_done", {31'd0, frame_ready}, 32'd0);

    // Garbage before a frame, then overrun while held.
    send(8'h00); send(8'hFF); send(8'h5A);
    check_eq("garb_busy", {31'd0, busy}, 32'd0);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check_eq("garb_ready", {31'd0, frame_ready}, 32'd1);
    check_eq("garb_len", {27'd0, frame_len}, 32'd1);
    send(8'hA5);
    check_eq("ovr_ready", {31'd0, frame_ready}, 32'd1);
    check_eq("ovr_busy", {31'd0, busy}, 32'd0);
    pulse("ovr_err", 4'b0001);
    pop("ovr_pop", 8'h7E);
    check_eq("ovr_done", {31'd0, frame_ready}, 32'd0);

    // Timeout after 1024 idle cycles.
    send(8'hA5); send(8'h02); send(8'hAA);
    tick(1023);
    check_eq("to_early_errs", {28'd0, errs}, 32'd0);
    check_eq("to_early_busy", {31'd0, busy}, 32'd1);
    tick(1);
    check_eq("to_busy", {31'd0, busy}, 32'd0);
    pulse("to_err", 4'b0010);

    // Byte lands in the expiry cycle: no timeout. 02^AA^BB = 13.
    send(8'hA5); send(8'h02); send(8'hAA);
    tick(1023);
    send(8'hBB);
    check_eq("to_race_errs", {28'd0, errs}, 32'd0);
    check_eq("to_race_busy", {31'd0, busy}, 32'd1);
    send(8'h13);
    check_eq("to_race_ready", {31'd0, frame_ready}, 32'd1);
    pop("to_race_pop0", 8'hAA);
    pop("to_race_pop1", 8'hBB);

    // Reset mid-payload.
    send(8'hA5); send(8'h04); send(8'h01);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, frame_ready}, 32'd0);
    check_eq("mid_rst_errs", {28'd0, errs}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    check_eq("mid_after_errs", {28'd0, errs}, 32'd0);
    check_eq("mid_after_busy", {31'd0, busy}, 32'd0);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check_eq("mid_recover", {31'd0, frame_ready}, 32'd1);
    pop("mid_recover_pop", 8'h7E);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
